smoldvi_link_ctrl: RTL and testbench
====================================

Name: smoldvi_link_ctrl

Overview:
Pixel-clock controller that sequences the DVI output path: raster timing generation plus link bring-up and teardown.
Produces the hsync/vsync/den/x/y stream consumed by the three TMDS encoders, whose symbols feed the per-lane serialisers.
Holds the link in blanking until the x5 serialiser domain reports ready, then sends a programmable number of blank-only frames before enabling active video.
Shuts down cleanly at a frame boundary.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, hsync active level (0 = active-low)
V_SYNC_POL, 0, vsync active level
WARMUP_FRAMES, 2, full blank-only frames sent before RUN (0 = skip WARMUP)
W_CNT, 12, width of x/y counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk_pix  in  1  pixel clock; the only clock
rst_pix  in  1  synchronous active-high reset
en  in  1  request link active; level-sensitive
phy_ready  in  1  serialiser/x5 domain out of reset; already synchronised to clk_pix
hsync  out  1  horizontal sync, polarity per H_SYNC_POL
vsync  out  1  vertical sync, polarity per V_SYNC_POL
den  out  1  active-video enable to the encoders
x  out  W_CNT  horizontal position
y  out  W_CNT  vertical position
frame_start  out  1  one-cycle pulse at x=0, y=0 while running
line_start  out  1  one-cycle pulse at x=0 while running
link_up  out  1  high in RUN or DRAIN
state  out  2  IDLE=0, WARMUP=1, RUN=2, DRAIN=3

Behaviour:
- Only one clock and one reset: clk_pix, with rst_pix synchronous active-high.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL analogous.
- Registered state: h, v counters, the FSM state, and the warmup frame counter. All outputs are decoded from these registers and are aligned to the same cycle.
- Reset (rst_pix=1 at a clock edge): state=IDLE, h=v=0, warmup count=0.
  - Outputs after reset: x=y=0, den=0, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL, frame_start=line_start=0, link_up=0.
  - Reset overrides all other inputs, including mid-frame.
- Counters:
  - h and v are held at 0 in IDLE; otherwise h increments every cycle.
  - At h=H_TOTAL-1, h wraps to 0 and v increments.
  - At v=V_TOTAL-1 together with h=H_TOTAL-1 (the frame end), v wraps to 0.
  - x=h and y=v.
- Decode:
  - hsync active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for the whole line (not pixel-aligned).
  - den = (h<H_ACTIVE) & (v<V_ACTIVE) & (state is RUN or DRAIN).
  - In IDLE, syncs are inactive and den=0.
  - frame_start = (h==0 & v==0 & state!=IDLE).
  - line_start = (h==0 & state!=IDLE).
- FSM:
  - IDLE -> WARMUP when en & phy_ready; go to RUN instead if WARMUP_FRAMES=0. The first non-IDLE cycle shows x=y=0 with frame_start=1.
  - WARMUP: counts completed frames. At the frame end of frame WARMUP_FRAMES it goes to RUN, so RUN starts at (0,0).
  - WARMUP with en=0 at the frame end -> IDLE.
  - RUN -> DRAIN when en=0.
  - DRAIN -> RUN if en=1 before the frame end; counters are unaffected (no gap).
  - DRAIN -> IDLE at the frame end with en=0.
  - Abort: phy_ready=0 in any non-IDLE state forces IDLE and h=v=0 on the next cycle, regardless of position in the frame. Priority: abort beats en.
  - The warmup count clears on entry to IDLE, so every restart performs the full warmup.
- Simultaneous events:
  - en dropping on the exact WARMUP->RUN frame-end cycle -> IDLE.
  - en dropping on the RUN frame-end cycle -> DRAIN for one whole further frame.

Test Plan:
Bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=16); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2 (V_TOTAL=8); WARMUP_FRAMES=2. One frame is 128 cycles.
- Reset/hold: rst_pix=1 then 0, with en=1 and phy_ready=0 for 300 cycles -> state=0, x=y=0, den=0, hsync=vsync=1, no pulses throughout.
- Bring-up: en=phy_ready=1 at edge T:
  - state=1 with frame_start=1 at T+1.
  - den=0 for 256 cycles.
  - state=2 at T+257 with x=y=0.
  - Thereafter exactly 32 den cycles per frame, at x 0..7, y 0..3.
- Sync placement in RUN:
  - hsync low exactly at x=10..12 on every line.
  - vsync low for all 16 cycles of y=5.
  - line_start once per 16 cycles; frame_start once per 128 cycles.
- Drain:
  - en=0 at x=3, y=2 -> state=3 next cycle; den continues normally; state=0 on the cycle after x=15, y=7.
  - Repeat with en=1 re-raised at y=6 -> state=2, counters continuous.
- Abort: phy_ready=0 at x=5, y=1 in RUN -> next cycle state=0, x=y=0, den=0. Re-raising phy_ready repeats the full 256-cycle WARMUP.
- Reset mid-run: rst_pix=1 for one cycle at x=4, y=3 in RUN -> next cycle all outputs at reset values and state=0.

Source files
------------

// File: rtl/smoldvi_link_ctrl.sv
`default_nettype none
// ============================================================================
// smoldvi_link_ctrl : DVI raster timing plus link bring-up/teardown sequencing
// Revision 1.0 - initial release
// ============================================================================
module smoldvi_link_ctrl #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter bit H_SYNC_POL    = 1'b0,
  parameter bit V_SYNC_POL    = 1'b0,
  parameter int WARMUP_FRAMES = 2,
  parameter int W_CNT         = 12
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             en,
  input  logic             phy_ready,
  output logic             hsync,
  output logic             vsync,
  output logic             den,
  output logic [W_CNT-1:0] x,
  output logic [W_CNT-1:0] y,
  output logic             frame_start,
  output logic             line_start,
  output logic             link_up,
  output logic [1:0]       state
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [W_CNT-1:0] H_LAST   = W_CNT'(H_TOTAL - 1);
  localparam logic [W_CNT-1:0] V_LAST   = W_CNT'(V_TOTAL - 1);
  localparam logic [W_CNT-1:0] H_ACT    = W_CNT'(H_ACTIVE);
  localparam logic [W_CNT-1:0] V_ACT    = W_CNT'(V_ACTIVE);
  localparam logic [W_CNT-1:0] H_SYNC_S = W_CNT'(H_ACTIVE + H_FP);
  localparam logic [W_CNT-1:0] H_SYNC_E = W_CNT'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [W_CNT-1:0] V_SYNC_S = W_CNT'(V_ACTIVE + V_FP);
  localparam logic [W_CNT-1:0] V_SYNC_E = W_CNT'(V_ACTIVE + V_FP + V_SYNC);

  // Warmup counter holds completed-frame index 0..WARMUP_FRAMES-1
  localparam int              W_WU    = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;
  localparam logic [W_WU-1:0] WU_LAST = W_WU'((WARMUP_FRAMES > 0) ? WARMUP_FRAMES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [W_CNT-1:0] h_q, h_d;
  logic [W_CNT-1:0] v_q, v_d;
  logic [W_WU-1:0]  wcnt_q, wcnt_d;

  logic w_h_last;
  logic w_frame_end;
  logic w_active;
  logic w_hs_win;
  logic w_vs_win;

  assign w_h_last    = (h_q == H_LAST);
  assign w_frame_end = w_h_last && (v_q == V_LAST);

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    wcnt_d  = wcnt_q;

    if (state_q != ST_IDLE) begin
      if (w_h_last) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (en && phy_ready) state_d = (WARMUP_FRAMES == 0) ? ST_RUN : ST_WARMUP;
      end
      ST_WARMUP: begin
        if (w_frame_end) begin
          if (!en)                    state_d = ST_IDLE;
          else if (wcnt_q == WU_LAST) state_d = ST_RUN;
          else                        wcnt_d  = wcnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!en) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (en)               state_d = ST_RUN;
        else if (w_frame_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Losing the serialiser drops the link immediately, wherever the raster is
    if ((state_q != ST_IDLE) && !phy_ready) begin
      state_d = ST_IDLE;
      h_d     = '0;
      v_d     = '0;
    end

    if (state_d == ST_IDLE) wcnt_d = '0;
  end

  assign w_active = (state_q != ST_IDLE);
  assign w_hs_win = (h_q >= H_SYNC_S) && (h_q < H_SYNC_E);
  assign w_vs_win = (v_q >= V_SYNC_S) && (v_q < V_SYNC_E);

  assign hsync       = (w_active && w_hs_win) ? H_SYNC_POL : ~H_SYNC_POL;
  assign vsync       = (w_active && w_vs_win) ? V_SYNC_POL : ~V_SYNC_POL;
  assign link_up     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign den         = (h_q < H_ACT) && (v_q < V_ACT) && link_up;
  assign x           = h_q;
  assign y           = v_q;
  assign line_start  = (h_q == '0) && w_active;
  assign frame_start = (h_q == '0) && (v_q == '0) && w_active;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_smoldvi_link_ctrl.sv
`default_nettype none
// ============================================================================
// tb_smoldvi_link_ctrl : directed self-checking bench, 16x8 raster, 2 warmup frames
// Revision 1.0 - initial release
// ============================================================================
module tb_smoldvi_link_ctrl;

  localparam int W = 12;

  logic         clk_pix = 1'b0;
  logic         rst_pix;
  logic         en;
  logic         phy_ready;
  logic         hsync, vsync, den, frame_start, line_start, link_up;
  logic [W-1:0] x, y;
  logic [1:0]   state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_pix = ~clk_pix;

  smoldvi_link_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
    .WARMUP_FRAMES(2), .W_CNT(W)
  ) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .en(en), .phy_ready(phy_ready),
    .hsync(hsync), .vsync(vsync), .den(den), .x(x), .y(y),
    .frame_start(frame_start), .line_start(line_start),
    .link_up(link_up), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_pos(input string tag, input int st, input int ex, input int ey);
    chk({tag, "_state"}, 32'(state), st);
    chk({tag, "_x"}, 32'(x), ex);
    chk({tag, "_y"}, 32'(y), ey);
  endtask

  initial begin
    int bad, dc, epos, eden, ehs, evs, els, efs;
    int ex, ey;

    rst_pix = 1'b1; en = 1'b0; phy_ready = 1'b0;
    tick();
    chk_pos("rst", 0, 0, 0);
    chk("rst_den", 32'(den), 0);
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_vsync", 32'(vsync), 1);
    chk("rst_link_up", 32'(link_up), 0);
    chk("rst_fs", 32'(frame_start), 0);

    // Hold in IDLE while the PHY is not ready
    rst_pix = 1'b0; en = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (state != 2'd0 || x != '0 || y != '0 || den || !hsync || !vsync ||
          frame_start || line_start || link_up) bad++;
    end
    chk("hold_bad_cycles", bad, 0);

    // Bring-up: 256 warmup cycles, then RUN at (0,0)
    phy_ready = 1'b1;
    tick();
    chk_pos("up_first", 1, 0, 0);
    chk("up_first_fs", 32'(frame_start), 1);
    chk("up_first_link_up", 32'(link_up), 0);
    bad = 0; dc = 0;
    for (int i = 2; i <= 256; i++) begin
      tick();
      dc += int'(den);
      if (state != 2'd1) bad++;
    end
    chk("warm_den_cycles", dc, 0);
    chk("warm_state_bad", bad, 0);
    tick();
    chk_pos("run_entry", 2, 0, 0);
    chk("run_entry_den", 32'(den), 1);
    chk("run_entry_link_up", 32'(link_up), 1);

    // One full RUN frame against hand timing: den x0..7 y0..3, hsync x10..12, vsync y5
    dc = 0; epos = 0; eden = 0; ehs = 0; evs = 0; els = 0; efs = 0;
    for (int i = 0; i < 128; i++) begin
      ex = i % 16; ey = i / 16;
      if (int'(x) != ex || int'(y) != ey || state != 2'd2) epos++;
      dc += int'(den);
      if (den != (ex < 8 && ey < 4)) eden++;
      if (hsync != !(ex >= 10 && ex <= 12)) ehs++;
      if (vsync != (ey != 5)) evs++;
      if (line_start != (ex == 0)) els++;
      if (frame_start != (ex == 0 && ey == 0)) efs++;
      tick();
    end
    chk("run_den_count", dc, 32);
    chk("run_pos_err", epos, 0);
    chk("run_den_err", eden, 0);
    chk("run_hsync_err", ehs, 0);
    chk("run_vsync_err", evs, 0);
    chk("run_line_start_err", els, 0);
    chk("run_frame_start_err", efs, 0);

    // Drain: en drops at (3,2), link closes at the frame end
    adv(35);
    chk_pos("pre_drain", 2, 3, 2);
    en = 1'b0;
    tick();
    chk_pos("drain", 3, 4, 2);
    chk("drain_den", 32'(den), 1);
    adv(91);
    chk_pos("drain_end", 3, 15, 7);
    tick();
    chk_pos("drain_idle", 0, 0, 0);
    chk("drain_idle_link_up", 32'(link_up), 0);

    // Drain cancelled by en re-raised at y=6
    en = 1'b1;
    tick();
    chk("rewarm_state", 32'(state), 1);
    adv(256);
    chk_pos("rerun", 2, 0, 0);
    adv(35);
    en = 1'b0;
    tick();
    chk("redrain_state", 32'(state), 3);
    adv(60);
    chk_pos("redrain_y6", 3, 0, 6);
    en = 1'b1;
    tick();
    chk_pos("resume", 2, 1, 6);
    adv(31);
    chk_pos("resume_wrap", 2, 0, 0);
    chk("resume_wrap_fs", 32'(frame_start), 1);

    // Abort on phy_ready loss mid-frame
    adv(21);
    chk_pos("pre_abort", 2, 5, 1);
    phy_ready = 1'b0;
    tick();
    chk_pos("abort", 0, 0, 0);
    chk("abort_den", 32'(den), 0);
    chk("abort_link_up", 32'(link_up), 0);
    tick();
    chk("abort_hold", 32'(state), 0);
    phy_ready = 1'b1;
    tick();
    chk_pos("abort_rewarm", 1, 0, 0);
    adv(255);
    chk_pos("abort_rewarm_end", 1, 15, 7);
    tick();
    chk_pos("abort_rerun", 2, 0, 0);

    // Reset in the middle of RUN
    adv(52);
    chk_pos("pre_rst", 2, 4, 3);
    rst_pix = 1'b1;
    tick();
    chk_pos("mid_rst", 0, 0, 0);
    chk("mid_rst_den", 32'(den), 0);
    chk("mid_rst_hsync", 32'(hsync), 1);
    chk("mid_rst_vsync", 32'(vsync), 1);
    chk("mid_rst_fs", 32'(frame_start), 0);
    chk("mid_rst_ls", 32'(line_start), 0);
    chk("mid_rst_link_up", 32'(link_up), 0);

    // en drops exactly on the WARMUP->RUN frame end
    rst_pix = 1'b0;
    tick();
    chk("wu_drop_start", 32'(state), 1);
    adv(255);
    chk_pos("wu_drop_end", 1, 15, 7);
    en = 1'b0;
    tick();
    chk_pos("wu_drop_idle", 0, 0, 0);

    // en drops exactly on a RUN frame end: one further full DRAIN frame
    en = 1'b1;
    tick();
    adv(256);
    chk_pos("fe_run", 2, 0, 0);
    adv(127);
    chk_pos("fe_run_end", 2, 15, 7);
    en = 1'b0;
    tick();
    chk_pos("fe_drain", 3, 0, 0);
    chk("fe_drain_den", 32'(den), 1);
    adv(127);
    chk_pos("fe_drain_end", 3, 15, 7);
    tick();
    chk_pos("fe_idle", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
